maze_dfs_walker: RTL

//  Depth-first maze solver driving the 16x16 1-bit maze memory; sits directly upstream of it.

---
 rtl/maze_pkg.sv | 52 +++++
 rtl/maze_dfs_walker_dir_stack.sv | 45 ++++
 rtl/maze_dfs_walker.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types for the 16x16 depth-first maze walker.
// Optional path streaming is enabled with the macro MAZE_PATH_OUT_EN.
package maze_pkg;

   localparam int COORD_W = 4;
   localparam int STK_AW  = 8;

   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
   localparam logic [COORD_W-1:0] C_MAX = '1;

   // Move directions; the numeric order is also the probe order.
   typedef enum logic [1:0] {
      UP    = 2'b00,
      RIGHT = 2'b01,
      LEFT  = 2'b10,
      DOWN  = 2'b11
   } dir_t;

`ifdef MAZE_PATH_OUT_EN
   typedef enum logic [2:0] {
      IDLE, CHK0, MARK, PROBE, BACK, DONE, FAIL, DUMP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, CHK0, MARK, PROBE, BACK, DONE, FAIL
   } state_t;
`endif

   // Neighbour coordinate plus an in-bounds flag (edges never wrap).
   typedef struct packed {
      logic               inb;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } nbr_t;

   function automatic nbr_t neighbour(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y,
                                      input dir_t d);
      nbr_t n;
      n.inb = 1'b1;
      n.x   = x;
      n.y   = y;
      case (d)
         UP:      begin n.inb = (x != '0);    n.x = x - C_ONE; end
         RIGHT:   begin n.inb = (y != C_MAX); n.y = y + C_ONE; end
         LEFT:    begin n.inb = (y != '0);    n.y = y - C_ONE; end
         default: begin n.inb = (x != C_MAX); n.x = x + C_ONE; end
      endcase
      return n;
   endfunction

endpackage

// File: rtl/maze_dfs_walker_dir_stack.sv
// dir_stack: 2-bit wide LIFO holding the move history of the walker.
// Synchronous push/pop/clear, combinational read at any index (the top is sp-1).
module dir_stack
   import maze_pkg::*;
#(
   parameter int STK_DEP = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [1:0]        din,
   input  logic [STK_AW-1:0] rd_idx,
   output logic [1:0]        rd_data,
   output logic [STK_AW:0]   sp,
   output logic              empty
);

   localparam logic [STK_AW:0] SP_ONE = (STK_AW+1)'(1);

   logic [1:0] stk [STK_DEP];

   // Stack pointer: cleared on reset or at the start of a new solve.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sp <= '0;
      end else if (push) begin
         sp <= sp + SP_ONE;
      end else if (pop) begin
         sp <= sp - SP_ONE;
      end
   end

   // Entry storage; contents need no reset because sp bounds every read.
   always_ff @(posedge clk) begin
      if (push) begin
         stk[sp[STK_AW-1:0]] <= din;
      end
   end

   assign rd_data = stk[rd_idx];
   assign empty   = (sp == '0);

endmodule

// File: rtl/maze_dfs_walker.sv
// maze_dfs_walker: depth-first solver for a 16x16 1-bit maze memory.
// Free cells read 0; visited cells are marked by writing 1. The move history
// lives in dir_stack so dead ends can be unwound one pop per cycle.
// Define MAZE_PATH_OUT_EN to stream the found path out on move/move_valid/move_last.
module maze_dfs_walker
   import maze_pkg::*;
#(
   parameter logic [COORD_W-1:0] GOAL_X  = 4'd15,
   parameter logic [COORD_W-1:0] GOAL_Y  = 4'd15,
   parameter int                 STK_DEP = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [COORD_W-1:0] mem_x,
   output logic [COORD_W-1:0] mem_y,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               mem_din,
   input  logic               mem_dout,
   output logic               done,
   output logic               fail,
   output logic [STK_AW:0]    path_len
`ifdef MAZE_PATH_OUT_EN
   ,
   output logic [1:0]         move,
   output logic               move_valid,
   output logic               move_last
`endif
);

   localparam logic [STK_AW-1:0] IDX_ONE = STK_AW'(1);

   state_t             state, state_n;
   logic [COORD_W-1:0] cur_x, cur_y, cur_x_n, cur_y_n;
   dir_t               try_dir, try_dir_n;
   dir_t               back_dir;
   nbr_t               nb;

   logic              push, pop, clr;
   logic [STK_AW-1:0] rd_idx, top_idx;
   logic [1:0]        rd_data;
   logic [STK_AW:0]   sp;
   logic              empty;

`ifdef MAZE_PATH_OUT_EN
   logic [STK_AW-1:0] dump_idx, dump_idx_n;
`endif

   dir_stack #(.STK_DEP(STK_DEP)) u_stack (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .push    (push),
      .pop     (pop),
      .din     (try_dir),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .sp      (sp),
      .empty   (empty)
   );

   assign mem_din  = 1'b1;
   assign top_idx  = sp[STK_AW-1:0] - IDX_ONE;
   assign nb       = neighbour(cur_x, cur_y, try_dir);
   assign back_dir = dir_t'(rd_data);

   // State, position and probe direction registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cur_x   <= '0;
         cur_y   <= '0;
         try_dir <= UP;
`ifdef MAZE_PATH_OUT_EN
         dump_idx <= '0;
`endif
      end else begin
         state   <= state_n;
         cur_x   <= cur_x_n;
         cur_y   <= cur_y_n;
         try_dir <= try_dir_n;
`ifdef MAZE_PATH_OUT_EN
         dump_idx <= dump_idx_n;
`endif
      end
   end

   // Next-state logic, memory handshake and status outputs.
   always_comb begin
      state_n   = state;
      cur_x_n   = cur_x;
      cur_y_n   = cur_y;
      try_dir_n = try_dir;
      push      = 1'b0;
      pop       = 1'b0;
      clr       = 1'b0;
      rd_idx    = top_idx;
      mem_x     = '0;
      mem_y     = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      done      = 1'b0;
      fail      = 1'b0;
      path_len  = '0;
`ifdef MAZE_PATH_OUT_EN
      dump_idx_n = dump_idx;
      move       = 2'b00;
      move_valid = 1'b0;
      move_last  = 1'b0;
`endif

      case (state)
         IDLE: ;

         CHK0: begin
            mem_rd  = 1'b1;
            state_n = mem_dout ? FAIL : MARK;
         end

         MARK: begin
            mem_wr    = 1'b1;
            mem_x     = cur_x;
            mem_y     = cur_y;
            try_dir_n = UP;
            if ((cur_x == GOAL_X) && (cur_y == GOAL_Y)) begin
`ifdef MAZE_PATH_OUT_EN
               dump_idx_n = '0;
               state_n    = empty ? DONE : DUMP;
`else
               state_n = DONE;
`endif
            end else begin
               state_n = PROBE;
            end
         end

         PROBE: begin
            if (nb.inb) begin
               mem_rd = 1'b1;
               mem_x  = nb.x;
               mem_y  = nb.y;
            end
            if (nb.inb && !mem_dout) begin
               push    = 1'b1;
               cur_x_n = nb.x;
               cur_y_n = nb.y;
               state_n = MARK;
            end else if (try_dir == DOWN) begin
               state_n = BACK;
            end else begin
               try_dir_n = dir_t'(try_dir + 2'd1);
            end
         end

         BACK: begin
            if (empty) begin
               state_n = FAIL;
            end else begin
               pop = 1'b1;
               case (back_dir)
                  UP:      cur_x_n = cur_x + C_ONE;
                  RIGHT:   cur_y_n = cur_y - C_ONE;
                  LEFT:    cur_y_n = cur_y + C_ONE;
                  default: cur_x_n = cur_x - C_ONE;
               endcase
               if (back_dir != DOWN) begin
                  try_dir_n = dir_t'(back_dir + 2'd1);
                  state_n   = PROBE;
               end
            end
         end

`ifdef MAZE_PATH_OUT_EN
         DUMP: begin
            rd_idx     = dump_idx;
            move       = rd_data;
            move_valid = 1'b1;
            if (dump_idx == top_idx) begin
               move_last = 1'b1;
               state_n   = DONE;
            end else begin
               dump_idx_n = dump_idx + IDX_ONE;
            end
         end
`endif

         DONE: begin
            done     = 1'b1;
            path_len = sp;
         end

         FAIL: begin
            fail = 1'b1;
         end

         default: state_n = IDLE;
      endcase

      if (start && ((state == IDLE) || (state == DONE) || (state == FAIL))) begin
         state_n   = CHK0;
         cur_x_n   = '0;
         cur_y_n   = '0;
         try_dir_n = UP;
         clr       = 1'b1;
      end
   end

endmodule
